// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor with valid/ready handshakes on both sides.
// The WIDTH-bit add is split into STAGES slices of WIDTH/STAGES bits.
// Operands are captured on acceptance. Each later clock adds one slice
// and passes its carry on to the next slice. A final register holds the
// result, the carry-out and the signed overflow flag.
// WIDTH must be an integer multiple of STAGES.
// Optional feature: define ADDSUB_SAT_EN to clamp results on signed overflow
// when the operand set was accepted with sat=1.
module pipelined_addsub #(
   parameter int WIDTH  = 6,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             sub,
   input  logic             sat,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] z,
   output logic             carry,
   output logic             overflow,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int SLICE = WIDTH / STAGES;
   localparam int LAST  = STAGES - 1;

   // Stage k holds the captured operands and the slices already summed.
   // It also holds the carry into slice k. Stage 0 has no slices summed yet.
   logic [STAGES-1:0] v_q, v_d;
   logic [STAGES-1:0] c_q, c_d;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  a_d [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  b_d [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];
   logic [WIDTH-1:0]  s_d [STAGES];
   logic [SLICE:0]    slice_sum [STAGES];

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] z_q, z_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] raw_sum;
   logic             msb_cin;
   logic             advance;

`ifdef ADDSUB_SAT_EN
   logic [STAGES-1:0] sat_q, sat_d;
`else
   logic unused_sat;
   assign unused_sat = sat;
`endif

   // The whole pipeline moves together unless the output is stalled.
   assign advance  = !out_valid_q || out_ready;
   assign in_ready = advance;

   // Slice adder for each stage: slice k of A, slice k of the addend, stage carry.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         slice_sum[k] = {1'b0, a_q[k][k*SLICE +: SLICE]}
                      + {1'b0, b_q[k][k*SLICE +: SLICE]}
                      + {{SLICE{1'b0}}, c_q[k]};
      end
   end

   // Next state of the stage registers: capture at stage 0, then one slice per stage.
   always_comb begin
      // NOTE: every variable gets a value on every path, so no latch is inferred.
      v_d    = '0;
      c_d    = '0;
      a_d    = '{default: '0};
      b_d    = '{default: '0};
      s_d    = '{default: '0};
      v_d[0] = in_valid;
      a_d[0] = x;
      b_d[0] = sub ? ~y : y;
      c_d[0] = sub;
      for (int k = 1; k < STAGES; k++) begin
         v_d[k] = v_q[k-1];
         a_d[k] = a_q[k-1];
         b_d[k] = b_q[k-1];
         s_d[k] = s_q[k-1];
         s_d[k][(k-1)*SLICE +: SLICE] = slice_sum[k-1][SLICE-1:0];
         c_d[k] = slice_sum[k-1][SLICE];
      end
   end

`ifdef ADDSUB_SAT_EN
   // The saturation request travels with its operands.
   always_comb begin
      sat_d    = '0;
      sat_d[0] = sat;
      for (int k = 1; k < STAGES; k++) begin
         sat_d[k] = sat_q[k-1];
      end
   end
`endif

   // Final slice, carry-out, overflow, and clamping when saturation is enabled.
   always_comb begin
      raw_sum = s_q[LAST];
      raw_sum[LAST*SLICE +: SLICE] = slice_sum[LAST][SLICE-1:0];
      carry_d = slice_sum[LAST][SLICE];
      // The carry into the MSB is recovered from the MSB sum bit and the MSB operand bits.
      msb_cin     = raw_sum[WIDTH-1] ^ a_q[LAST][WIDTH-1] ^ b_q[LAST][WIDTH-1];
      ovf_d       = msb_cin ^ carry_d;
      out_valid_d = v_q[LAST];
      z_d         = raw_sum;
`ifdef ADDSUB_SAT_EN
      // On overflow the two operand signs match, so A's sign gives the true sign.
      if (sat_q[LAST] && ovf_d) begin
         z_d = a_q[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   // Pipeline and output registers: cleared on reset, held during a stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the datapath arrays are reset as well as the valid bits,
         // so that z, carry and overflow read zero while reset is held.
         v_q         <= '0;
         c_q         <= '0;
         a_q         <= '{default: '0};
         b_q         <= '{default: '0};
         s_q         <= '{default: '0};
         out_valid_q <= 1'b0;
         z_q         <= '0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
      end else if (advance) begin
         // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
         v_q         <= v_d;
         c_q         <= c_d;
         a_q         <= a_d;
         b_q         <= b_d;
         s_q         <= s_d;
         out_valid_q <= out_valid_d;
         z_q         <= z_d;
         carry_q     <= carry_d;
         ovf_q       <= ovf_d;
      end
   end

`ifdef ADDSUB_SAT_EN
   // Saturation-request pipeline, advancing in step with the operands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sat_q <= '0;
      end else if (advance) begin
         sat_q <= sat_d;
      end
   end
`endif

   assign out_valid = out_valid_q;
   assign z         = z_q;
   assign carry     = carry_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub with WIDTH=6 and STAGES=2.
// The stimulus pushes the hand-computed expected result when an operand set
// is accepted. A monitor pops and compares each consumed result.
module tb_pipelined_addsub;

   typedef struct {
      logic [5:0] z;
      logic       c;
      logic       o;
   } exp_t;

`ifdef ADDSUB_SAT_EN
   localparam logic [5:0] SAT_Z = 6'd31;
`else
   localparam logic [5:0] SAT_Z = 6'd32;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] x, y;
   logic       sub, sat, in_valid, in_ready;
   logic [5:0] z;
   logic       carry, overflow, out_valid, out_ready;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   n_popped = 0;
   int   last_pop_cyc = 0;
   int   prev_pop_cyc = 0;
   exp_t sb [$];
   exp_t e_mon;

   pipelined_addsub #(.WIDTH(6), .STAGES(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .x         (x),
      .y         (y),
      .sub       (sub),
      .sat       (sat),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .z         (z),
      .carry     (carry),
      .overflow  (overflow),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: compare every consumed result against the oldest pending expectation.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got z=%0d, expected no result", z);
         end else begin
            e_mon = sb.pop_front();
            check("z", {26'd0, z}, {26'd0, e_mon.z});
            check("carry", {31'd0, carry}, {31'd0, e_mon.c});
            check("overflow", {31'd0, overflow}, {31'd0, e_mon.o});
         end
         n_popped++;
         prev_pop_cyc = last_pop_cyc;
         last_pop_cyc = cyc;
      end
   end

   // Present one operand set and hold it until it is accepted (bounded wait).
   task automatic send(input logic [5:0] xv, input logic [5:0] yv, input logic sv,
                       input logic satv, input logic [5:0] ez, input logic ec,
                       input logic eo, input bit push);
      exp_t e;
      bit   acc;
      int   waitc;
      x = xv; y = yv; sub = sv; sat = satv; in_valid = 1'b1;
      acc = 1'b0;
      waitc = 0;
      while (!acc) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         if (acc && push) begin
            e.z = ez; e.c = ec; e.o = eo;
            sb.push_back(e);
         end
         #1;
         if (!acc) begin
            waitc++;
            if (waitc > 20) begin
               n_tests++;
               n_fail++;
               $display("FAIL accept_timeout: got no accept in %0d cycles, expected accept", waitc);
               acc = 1'b1;
            end
         end
      end
   endtask

   // Wait (bounded) until every expected result has been consumed.
   task automatic drain();
      int waitc;
      waitc = 0;
      while (sb.size() != 0 && waitc < 50) begin
         @(posedge clk);
         waitc++;
      end
      check("drain_pending", sb.size(), 0);
      #1;
   endtask

   initial begin
      int c0, p0, spurious;
      reset = 1'b1; x = '0; y = '0; sub = 1'b0; sat = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1;

      // Reset state
      #3;
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_z", {26'd0, z}, 0);
      check("rst_carry", {31'd0, carry}, 0);
      check("rst_overflow", {31'd0, overflow}, 0);
      check("rst_in_ready", {31'd0, in_ready}, 1);
      @(posedge clk); #1;
      reset = 1'b0;

      // 63+1 wraps to 0 with carry; accepted on the first edge, result 2 cycles later
      c0 = cyc;
      send(6'd63, 6'd1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b1);
      in_valid = 1'b0;
      check("first_accept_edge", cyc - c0, 1);
      @(negedge clk);
      check("lat_after_edge1", {31'd0, out_valid}, 0);
      @(negedge clk);
      check("lat_after_edge2", {31'd0, out_valid}, 0);
      @(negedge clk);
      check("lat_after_edge3", {31'd0, out_valid}, 1);
      drain();

      // Signed overflow with and without sat, then the subtraction cases
      send(6'd31, 6'd1, 1'b0, 1'b0, 6'd32, 1'b0, 1'b1, 1'b1);
      send(6'd31, 6'd1, 1'b0, 1'b1, SAT_Z, 1'b0, 1'b1, 1'b1);
      send(6'd5,  6'd7, 1'b1, 1'b0, 6'd62, 1'b0, 1'b0, 1'b1);
      send(6'd7,  6'd5, 1'b1, 1'b0, 6'd2,  1'b1, 1'b0, 1'b1);
      in_valid = 1'b0;
      drain();

      // Four back-to-back sets with out_ready low for 3 cycles from cycle 3
      p0 = n_popped;
      fork
         begin
            send(6'd1,  6'd2,  1'b0, 1'b0, 6'd3,  1'b0, 1'b0, 1'b1);
            send(6'd10, 6'd20, 1'b0, 1'b0, 6'd30, 1'b0, 1'b0, 1'b1);
            send(6'd40, 6'd30, 1'b0, 1'b0, 6'd6,  1'b1, 1'b0, 1'b1);
            send(6'd32, 6'd1,  1'b1, 1'b0, 6'd31, 1'b1, 1'b1, 1'b1);
            in_valid = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check("stall_in_ready", {31'd0, in_ready}, 0);
               check("stall_out_valid", {31'd0, out_valid}, 1);
               check("stall_z_held", {26'd0, z}, 3);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();
      check("stall_result_count", n_popped - p0, 4);

      // Reset one cycle after an accept discards the in-flight set
      send(6'd3, 6'd4, 1'b0, 1'b0, 6'd7, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("async_rst_out_valid", {31'd0, out_valid}, 0);
      check("async_rst_z", {26'd0, z}, 0);
      check("async_rst_carry", {31'd0, carry}, 0);
      check("async_rst_overflow", {31'd0, overflow}, 0);
      check("async_rst_in_ready", {31'd0, in_ready}, 1);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      p0 = n_popped;
      spurious = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) spurious++;
      end
      check("no_result_after_reset", spurious, 0);
      check("no_pop_after_reset", n_popped - p0, 0);
      @(posedge clk); #1;

      // in_valid 1,0,1: two results separated by one bubble
      p0 = n_popped;
      send(6'd9, 6'd9, 1'b0, 1'b0, 6'd18, 1'b0, 1'b0, 1'b1);
      in_valid = 1'b0;
      @(posedge clk); #1;
      send(6'd20, 6'd50, 1'b1, 1'b0, 6'd34, 1'b0, 1'b1, 1'b1);
      in_valid = 1'b0;
      drain();
      check("bubble_result_count", n_popped - p0, 2);
      check("bubble_gap", last_pop_cyc - prev_pop_cyc, 2);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pipelined_addsub.md
PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter STAGES, default 2, meaning the number of pipeline stages; WIDTH SHALL be an integer multiple of STAGES, and each stage SHALL add one WIDTH/STAGES-bit slice.
REQ-003 The block SHALL have one clock, clk, input, 1 bit, rising-edge.
REQ-004 The block SHALL have reset, input, 1 bit, asynchronous, active-high.
REQ-005 The block SHALL have x, input, WIDTH bits, operand A.
REQ-006 The block SHALL have y, input, WIDTH bits, operand B.
REQ-007 The block SHALL have sub, input, 1 bit; 0 = A+B, 1 = A-B.
REQ-008 The block SHALL have sat, input, 1 bit, saturation request; it is effective only per REQ-030.
REQ-009 The block SHALL have in_valid, input, 1 bit, and in_ready, output, 1 bit, forming the operand handshake.
REQ-010 The block SHALL have z, output, WIDTH bits, the result.
REQ-011 The block SHALL have carry, output, 1 bit: the carry-out of the MSB (for subtraction, 1 = no borrow).
REQ-012 The block SHALL have overflow, output, 1 bit, the signed two's-complement overflow flag.
REQ-013 The block SHALL have out_valid, output, 1 bit, and out_ready, input, 1 bit, forming the result handshake.

Function
REQ-014 An operand set SHALL be accepted on a rising clk edge where in_valid=1 and in_ready=1.
REQ-015 The effective addend SHALL be y for sub=0 and ~y for sub=1, with a carry-in of 0 for sub=0 and 1 for sub=1.
REQ-016 Stage k SHALL add slice k of x and the effective addend, plus the carry registered from stage k-1; the remaining upper slices SHALL be registered unchanged alongside.
REQ-017 An accepted set SHALL produce out_valid=1 with its result exactly STAGES cycles after acceptance when there is no stall.
REQ-018 A result SHALL be consumed on an edge with out_valid=1 and out_ready=1.
REQ-019 A stall SHALL exist when out_valid=1 and out_ready=0; during a stall every stage SHALL hold its contents and in_ready SHALL be 0.
REQ-020 in_ready SHALL equal (!out_valid || out_ready), and SHALL be combinational with no dependency on in_valid.
REQ-021 Each stage SHALL carry its own valid bit, and bubbles SHALL propagate without producing a result.
REQ-022 Full throughput SHALL be one result per cycle while out_ready=1.
REQ-023 overflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-024 z, carry and overflow SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 Results SHALL leave the block in acceptance order, with no loss and no duplication.

Reset
REQ-026 When reset is asserted, all stage valid bits SHALL clear asynchronously, and out_valid, z, carry and overflow SHALL be 0.
REQ-027 Operands in flight when reset is asserted SHALL be discarded, and no result for them SHALL appear after reset is released.
REQ-028 in_ready SHALL be 1 while reset is asserted and after reset is released.
REQ-029 The first accept SHALL be possible on the first rising edge after reset is released.

Configuration
REQ-030 Macro ADDSUB_SAT_EN: when it is defined, a result whose sat bit was 1 at acceptance SHALL be clamped on overflow, to 2^(WIDTH-1)-1 when positive and to -2^(WIDTH-1) when negative; carry and overflow SHALL still report the unclamped values.
REQ-031 When ADDSUB_SAT_EN is not defined, sat SHALL be ignored, results SHALL wrap modulo 2^WIDTH, and no saturation logic SHALL be synthesised.

Verification (WIDTH=6, STAGES=2)
REQ-032 The bench SHALL cover: x=63, y=1, sub=0 -> z=0, carry=1, overflow=0, out_valid exactly 2 cycles after accept.
REQ-033 The bench SHALL cover: x=31, y=1, sub=0, sat=0 -> z=32, carry=0, overflow=1; with ADDSUB_SAT_EN defined and sat=1 -> z=31, overflow=1.
REQ-034 The bench SHALL cover: x=5, y=7, sub=1 -> z=62, carry=0 (borrow), overflow=0; and x=7, y=5, sub=1 -> z=2, carry=1.
REQ-035 The bench SHALL cover: 4 back-to-back accepts with out_ready=0 from cycle 3 for 3 cycles -> in_ready=0 during the stall, z held constant, all 4 results delivered in order with none lost.
REQ-036 The bench SHALL cover: reset asserted 1 cycle after an accept -> out_valid=0 immediately, and no result for that operand set after reset is released.
REQ-037 The bench SHALL cover: in_valid toggling 1,0,1 -> exactly 2 results, separated by a 1-cycle bubble.
